a2bus_cycle_capture: RTL and testbench

Parametrised successor to the Apple II bus sampling stage. It counts `clk_logic_i` cycles within each Phi phase and samples address, R/W and data at tunable offsets. Each completed bus cycle becomes a record in a first-word-fall-through FIFO, so slow consumers (bus monitors, debug UART, cards) never miss a cycle. It sits between `a2bus_timing` (phase strobes) and device logic.

---
 rtl/a2bus_cycle_capture.sv | 219 +++++++++++++++++++++
 tb/tb_a2bus_cycle_capture.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2bus_cycle_capture.sv
// a2bus_cycle_capture
// Samples the Apple II address, R/W and data buses at fixed clk_logic offsets
// inside each Phi phase and queues every completed bus cycle as a record in a
// first-word-fall-through FIFO.
// Optional feature: define A2BUS_CAPTURE_FILTER_EN to queue only cycles whose
// address lies inside [filter_lo_i, filter_hi_i].
module a2bus_cycle_capture #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_COUNT    = 18,
    parameter int DATA_COUNT    = 15,
    parameter int SLEEP_COUNT   = 63,
    parameter int FIFO_DEPTH    = 8,
    parameter int CAPTURE_READS = 1
) (
    input  logic                          clk_logic_i,
    input  logic                          system_reset_n_i,
    input  logic                          phi0_i,
    input  logic                          phi1_i,
    input  logic                          phi1_posedge_i,
    input  logic                          phi1_negedge_i,
    input  logic [ADDR_WIDTH-1:0]         a2_a_i,
    input  logic [DATA_WIDTH-1:0]         a2_d_i,
    input  logic                          a2_rw_n_i,
    output logic [ADDR_WIDTH-1:0]         addr_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          rw_n_o,
    output logic                          addr_strobe_o,
    output logic                          data_in_strobe_o,
    output logic                          sleep_o,
    output logic                          rec_valid_o,
    input  logic                          rec_ready_i,
    output logic [ADDR_WIDTH-1:0]         rec_addr_o,
    output logic [DATA_WIDTH-1:0]         rec_data_o,
    output logic                          rec_rw_n_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic [7:0]                    overflow_cnt_o,
    input  logic                          overflow_clr_i,
    input  logic [ADDR_WIDTH-1:0]         filter_lo_i,
    input  logic [ADDR_WIDTH-1:0]         filter_hi_i
);

    localparam int CNT_W = $clog2(SLEEP_COUNT + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  rw_n;
    } rec_t;

    // Phase counter
    logic [CNT_W-1:0]      count_q, count_d;

    // Sampled bus values and strobes
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rw_n_q, rw_n_d;
    logic                  addr_stb_q, addr_stb_d;
    logic                  data_stb_q, data_stb_d;
    logic                  pending_q, pending_d;
    logic                  push_q, push_d;
    rec_t                  push_rec_q, push_rec_d;

    // Record FIFO
    rec_t                  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [7:0]            ovf_q, ovf_d;

    logic                  addr_sample;
    logic                  data_sample;
    logic                  in_window;
    logic                  full;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;
    rec_t                  head;

`ifdef A2BUS_CAPTURE_FILTER_EN
    assign in_window = (addr_q >= filter_lo_i) && (addr_q <= filter_hi_i);
`else
    logic unused_filter;
    assign in_window     = 1'b1;
    assign unused_filter = ^{filter_lo_i, filter_hi_i};
`endif

    assign addr_sample = phi1_i && (count_q == CNT_W'(ADDR_COUNT));
    assign data_sample = phi0_i && (count_q == CNT_W'(DATA_COUNT));

    // Phase counter: restart on either Phi1 edge, otherwise count up and stick at SLEEP_COUNT.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_d = count_q;
        if (phi1_posedge_i || phi1_negedge_i) begin
            count_d = '0;
        end else if (count_q != CNT_W'(SLEEP_COUNT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Bus sampling: latch address/rw and data at their offsets, schedule a record push.
    always_comb begin
        addr_d     = addr_q;
        rw_n_d     = rw_n_q;
        data_d     = data_q;
        pending_d  = pending_q;
        push_d     = 1'b0;
        push_rec_d = push_rec_q;
        addr_stb_d = addr_sample;
        data_stb_d = data_sample;
        if (data_sample) begin
            if (!rw_n_q || (CAPTURE_READS != 0)) begin
                data_d = a2_d_i;
            end
            // The record carries the freshly sampled data, not the stale register.
            if (pending_q && in_window) begin
                push_d          = 1'b1;
                push_rec_d.addr = addr_q;
                push_rec_d.data = data_d;
                push_rec_d.rw_n = rw_n_q;
            end
            pending_d = 1'b0;
        end
        if (addr_sample) begin
            addr_d    = a2_a_i;
            rw_n_d    = a2_rw_n_i;
            pending_d = 1'b1;
        end
    end

    // FIFO bookkeeping: a push into a full FIFO still lands when a pop frees a slot that cycle.
    always_comb begin
        full     = (level_q == LVL_W'(FIFO_DEPTH));
        pop      = (level_q != '0) && rec_ready_i;
        push_ok  = push_q && (!full || pop);
        drop     = push_q && !push_ok;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push_ok) begin
            level_d = level_q - LVL_W'(1);
        end
        if (overflow_clr_i) begin
            ovf_d = '0;
        end else if (drop && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_logic_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!system_reset_n_i) begin
            count_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rw_n_q     <= 1'b1;
            addr_stb_q <= 1'b0;
            data_stb_q <= 1'b0;
            pending_q  <= 1'b0;
            push_q     <= 1'b0;
            push_rec_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= '0;
        end else begin
            count_q    <= count_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rw_n_q     <= rw_n_d;
            addr_stb_q <= addr_stb_d;
            data_stb_q <= data_stb_d;
            pending_q  <= pending_d;
            push_q     <= push_d;
            push_rec_q <= push_rec_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
        end
    end

    // Record storage.
    always_ff @(posedge clk_logic_i) begin
        // NOTE: the storage array has no reset; empty-FIFO outputs are forced to reset values below instead.
        if (push_ok) begin
            mem[wr_ptr_q] <= push_rec_q;
        end
    end

    assign head = mem[rd_ptr_q];

    assign addr_o           = addr_q;
    assign data_o           = data_q;
    assign rw_n_o           = rw_n_q;
    assign addr_strobe_o    = addr_stb_q;
    assign data_in_strobe_o = data_stb_q;
    assign sleep_o          = (count_q == CNT_W'(SLEEP_COUNT));
    assign rec_valid_o      = (level_q != '0);
    assign rec_addr_o       = rec_valid_o ? head.addr : '0;
    assign rec_data_o       = rec_valid_o ? head.data : '0;
    assign rec_rw_n_o       = rec_valid_o ? head.rw_n : 1'b1;
    assign level_o          = level_q;
    assign overflow_cnt_o   = ovf_q;

endmodule

// File: tb/tb_a2bus_cycle_capture.sv
// Testbench for a2bus_cycle_capture: directed table, hand sequences and random
// bus cycles checked every clock against a queue-based reference model.
// Honours A2BUS_CAPTURE_FILTER_EN when the design is built with it.
module tb_a2bus_cycle_capture;

    localparam int DEPTH = 8;
    localparam int SLEEP = 63;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rw_n;
    } rec_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rw;
        logic        ready;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic        e_rw;
        int          e_level;
        int          e_vcyc;
        logic [7:0]  e_data2;
        logic        chk_rec2;
        logic [7:0]  e_rec2_data;
        logic        e_rec2_rw;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, phi0, phi1, ppos, pneg, rw, ready, clr;
    logic [15:0] a, lo, hi;
    logic [7:0]  d;

    logic [15:0] addr_o, raddr, addr_o2, raddr2;
    logic [7:0]  data_o, rdata, ovf, data_o2, rdata2, ovf2;
    logic        rw_n_o, astb, dstb, sleep, rvalid, rrw;
    logic        rw_n_o2, astb2, dstb2, sleep2, rvalid2, rrw2;
    logic [3:0]  level, level2;

    a2bus_cycle_capture dut (
        .clk_logic_i(clk), .system_reset_n_i(rst_n),
        .phi0_i(phi0), .phi1_i(phi1), .phi1_posedge_i(ppos), .phi1_negedge_i(pneg),
        .a2_a_i(a), .a2_d_i(d), .a2_rw_n_i(rw),
        .addr_o(addr_o), .data_o(data_o), .rw_n_o(rw_n_o),
        .addr_strobe_o(astb), .data_in_strobe_o(dstb), .sleep_o(sleep),
        .rec_valid_o(rvalid), .rec_ready_i(ready),
        .rec_addr_o(raddr), .rec_data_o(rdata), .rec_rw_n_o(rrw),
        .level_o(level), .overflow_cnt_o(ovf), .overflow_clr_i(clr),
        .filter_lo_i(lo), .filter_hi_i(hi)
    );

    a2bus_cycle_capture #(.CAPTURE_READS(0)) dut2 (
        .clk_logic_i(clk), .system_reset_n_i(rst_n),
        .phi0_i(phi0), .phi1_i(phi1), .phi1_posedge_i(ppos), .phi1_negedge_i(pneg),
        .a2_a_i(a), .a2_d_i(d), .a2_rw_n_i(rw),
        .addr_o(addr_o2), .data_o(data_o2), .rw_n_o(rw_n_o2),
        .addr_strobe_o(astb2), .data_in_strobe_o(dstb2), .sleep_o(sleep2),
        .rec_valid_o(rvalid2), .rec_ready_i(ready),
        .rec_addr_o(raddr2), .rec_data_o(rdata2), .rec_rw_n_o(rrw2),
        .level_o(level2), .overflow_cnt_o(ovf2), .overflow_clr_i(clr),
        .filter_lo_i(lo), .filter_hi_i(hi)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: bus rules in integer form, FIFO as a queue.
    int          m_cnt;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    logic        m_rw, m_pend, m_push, m_astb, m_dstb;
    rec_t        m_push_rec;
    rec_t        m_q[$];
    int          m_ovf;

    task automatic model_edge();
        bit   win, a_hit, d_hit;
        rec_t r;
        if (!rst_n) begin
            m_cnt = 0; m_addr = '0; m_data = '0; m_rw = 1'b1; m_pend = 1'b0;
            m_push = 1'b0; m_q.delete(); m_ovf = 0; m_astb = 1'b0; m_dstb = 1'b0;
            return;
        end
        if (m_q.size() != 0 && ready) r = m_q.pop_front();
        if (m_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_push_rec);
            else if (m_ovf < 255) m_ovf++;
        end
        if (clr) m_ovf = 0;
        m_push = 1'b0;
        a_hit = phi1 && (m_cnt == 18);
        d_hit = phi0 && (m_cnt == 15);
`ifdef A2BUS_CAPTURE_FILTER_EN
        win = (m_addr >= lo) && (m_addr <= hi);
`else
        win = 1'b1;
`endif
        if (d_hit) begin
            m_data = d;
            if (m_pend && win) begin
                m_push = 1'b1;
                m_push_rec.addr = m_addr;
                m_push_rec.data = m_data;
                m_push_rec.rw_n = m_rw;
            end
            m_pend = 1'b0;
        end
        if (a_hit) begin
            m_addr = a; m_rw = rw; m_pend = 1'b1;
        end
        m_astb = a_hit;
        m_dstb = d_hit;
        m_cnt  = (ppos || pneg) ? 0 : ((m_cnt < SLEEP) ? m_cnt + 1 : SLEEP);
    endtask

    task automatic compare_all();
        rec_t h;
        h.addr = '0; h.data = '0; h.rw_n = 1'b1;
        if (m_q.size() != 0) h = m_q[0];
        check("addr_o",      32'(addr_o), 32'(m_addr));
        check("data_o",      32'(data_o), 32'(m_data));
        check("rw_n_o",      32'(rw_n_o), 32'(m_rw));
        check("addr_strobe", 32'(astb),   32'(m_astb));
        check("data_strobe", 32'(dstb),   32'(m_dstb));
        check("sleep_o",     32'(sleep),  32'(m_cnt == SLEEP));
        check("rec_valid",   32'(rvalid), 32'(m_q.size() != 0));
        check("level_o",     32'(level),  32'(m_q.size()));
        check("overflow",    32'(ovf),    32'(m_ovf));
        check("rec_addr",    32'(raddr),  32'(h.addr));
        check("rec_data",    32'(rdata),  32'(h.data));
        check("rec_rw_n",    32'(rrw),    32'(h.rw_n));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    int         valid_cyc, dstb2_cnt;
    logic [7:0] rec2_data;
    logic       rec2_rw;

    // One bus cycle: len1 clocks of Phi1 then len0 clocks of Phi0.
    // rmode 0/1 holds rec_ready, 2 randomises ready and clear; pulse_at/rst_at index the whole cycle.
    task automatic bus_cycle(input int len1, input int len0, input logic [15:0] ad,
                             input logic [7:0] dt, input logic rwv, input int rmode,
                             input int pulse_at, input int rst_at);
        valid_cyc = 0; dstb2_cnt = 0; rec2_data = '0; rec2_rw = 1'b0;
        for (int g = 0; g < len1 + len0; g++) begin
            int c;
            bit ph1;
            ph1   = (g < len1);
            c     = ph1 ? g : g - len1;
            phi1  = ph1;
            phi0  = !ph1;
            ppos  = ph1 && (c == 0);
            pneg  = !ph1 && (c == 0);
            a     = (ph1 && c == 19) ? ad : 16'($urandom);
            rw    = (ph1 && c == 19) ? rwv : 1'($urandom);
            d     = (!ph1 && c == 16) ? dt : 8'($urandom);
            ready = (rmode == 2) ? 1'($urandom) : ((g == pulse_at) ? 1'b1 : (rmode == 1));
            clr   = (rmode == 2) ? ($urandom_range(0, 15) == 0) : 1'b0;
            rst_n = (g != rst_at);
            step();
            if (rvalid) valid_cyc++;
            if (dstb2) dstb2_cnt++;
            if (rvalid2 && ready) begin
                rec2_data = rdata2;
                rec2_rw   = rrw2;
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            phi0 = 1'b0; phi1 = 1'b0; ppos = 1'b0; pneg = 1'b0;
            ready = rdy; clr = 1'b0; rst_n = 1'b1;
            a = 16'($urandom); d = 8'($urandom); rw = 1'($urandom);
            step();
        end
    endtask

    vec_t vt[5];

    initial begin
        vt[0] = '{16'hC0E0, 8'h5A, 1'b0, 1'b1, 16'hC0E0, 8'h5A, 1'b0, 0, 1,  8'h5A, 1'b1, 8'h5A, 1'b0};
        vt[1] = '{16'h1234, 8'h33, 1'b1, 1'b1, 16'h1234, 8'h33, 1'b1, 0, 1,  8'h5A, 1'b1, 8'h5A, 1'b1};
        vt[2] = '{16'hFFFF, 8'h00, 1'b0, 1'b0, 16'hFFFF, 8'h00, 1'b0, 1, 9,  8'h00, 1'b0, 8'h00, 1'b0};
        vt[3] = '{16'h0000, 8'hFF, 1'b1, 1'b0, 16'h0000, 8'hFF, 1'b1, 2, 52, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[4] = '{16'h8001, 8'hA5, 1'b1, 1'b1, 16'h8001, 8'hA5, 1'b1, 0, 2,  8'h00, 1'b1, 8'h00, 1'b1};

        rst_n = 1'b0; phi0 = 1'b0; phi1 = 1'b0; ppos = 1'b0; pneg = 1'b0;
        rw = 1'b1; ready = 1'b0; clr = 1'b0; a = '0; d = '0; lo = '0; hi = 16'hFFFF;

        // Reset values
        step();
        step();
        check("rst_addr_o",   32'(addr_o), 32'h0);
        check("rst_data_o",   32'(data_o), 32'h0);
        check("rst_rw_n_o",   32'(rw_n_o), 32'h1);
        check("rst_rec_rw_n", 32'(rrw),    32'h1);
        check("rst_level",    32'(level),  32'h0);
        check("rst_sleep",    32'(sleep),  32'h0);
        check("rst_valid",    32'(rvalid), 32'h0);
        check("rst_overflow", 32'(ovf),    32'h0);

        // Data phase with no preceding address sample: latches data, queues nothing
        bus_cycle(0, 26, 16'h0, 8'h77, 1'b0, 1, -1, -1);
        check("orphan_data",   32'(data_o),  32'h77);
        check("orphan_level",  32'(level),   32'h0);
        check("orphan_data2",  32'(data_o2), 32'h0);

        // Directed 52-clock bus cycles
        for (int i = 0; i < 5; i++) begin
            bus_cycle(26, 26, vt[i].addr, vt[i].data, vt[i].rw, vt[i].ready ? 1 : 0, -1, -1);
            check("tbl_addr_o",   32'(addr_o),    32'(vt[i].e_addr));
            check("tbl_data_o",   32'(data_o),    32'(vt[i].e_data));
            check("tbl_rw_n_o",   32'(rw_n_o),    32'(vt[i].e_rw));
            check("tbl_level",    32'(level),     32'(vt[i].e_level));
            check("tbl_valid_cyc", 32'(valid_cyc), 32'(vt[i].e_vcyc));
            check("tbl_cr0_data", 32'(data_o2),   32'(vt[i].e_data2));
            check("tbl_cr0_dstb", 32'(dstb2_cnt), 32'd1);
            if (vt[i].chk_rec2) begin
                check("tbl_cr0_rec_data", 32'(rec2_data), 32'(vt[i].e_rec2_data));
                check("tbl_cr0_rec_rw",   32'(rec2_rw),   32'(vt[i].e_rec2_rw));
            end
        end

        // Overflow: 10 cycles with no consumer, then pop in order and clear
        idle(4, 1'b1);
        for (int i = 0; i < 10; i++) bus_cycle(26, 26, 16'h2000 + 16'(i), 8'(i), 1'b0, 0, -1, -1);
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_count", 32'(ovf),   32'd2);
        for (int i = 0; i < 8; i++) begin
            check("pop_order_addr", 32'(raddr), 32'h2000 + 32'(i));
            check("pop_order_data", 32'(rdata), 32'(i));
            idle(1, 1'b1);
        end
        check("pop_empty", 32'(level), 32'd0);
        check("ovf_kept",  32'(ovf),   32'd2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Full FIFO with a pop on the push cycle
        for (int i = 0; i < 8; i++) bus_cycle(26, 26, 16'h3000 + 16'(i), 8'h30 + 8'(i), 1'b1, 0, -1, -1);
        check("full_level", 32'(level), 32'd8);
        bus_cycle(26, 26, 16'h3008, 8'h88, 1'b0, 0, 43, -1);
        check("full_pp_level", 32'(level), 32'd8);
        check("full_pp_ovf",   32'(ovf),   32'd0);
        check("full_pp_head",  32'(raddr), 32'h3001);
        idle(10, 1'b1);
        check("full_drained", 32'(level), 32'd0);

        // Sleep: no Phi edges for 70 clocks
        phi0 = 1'b0; phi1 = 1'b0; ppos = 1'b1; pneg = 1'b0; ready = 1'b1;
        step();
        ppos = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            step();
            if (n == 62) check("sleep_at_62", 32'(sleep), 32'd0);
            if (n == 63) check("sleep_at_63", 32'(sleep), 32'd1);
        end
        check("sleep_held", 32'(sleep), 32'd1);
        pneg = 1'b1;
        step();
        pneg = 1'b0;
        check("sleep_wake", 32'(sleep), 32'd0);

        // Reset in the middle of a cycle, after the address sample
        bus_cycle(26, 26, 16'h5000, 8'h50, 1'b0, 0, -1, -1);
        bus_cycle(26, 26, 16'h5001, 8'h51, 1'b0, 0, -1, -1);
        check("pre_rst_level", 32'(level), 32'd2);
        bus_cycle(26, 26, 16'h4444, 8'h44, 1'b0, 0, -1, 22);
        check("midrst_addr",  32'(addr_o), 32'h0);
        check("midrst_rw",    32'(rw_n_o), 32'h1);
        check("midrst_level", 32'(level),  32'h0);
        check("midrst_valid", 32'(rvalid), 32'h0);

`ifdef A2BUS_CAPTURE_FILTER_EN
        // Address window
        lo = 16'hC080; hi = 16'hC08F;
        bus_cycle(26, 26, 16'hC081, 8'h11, 1'b0, 0, -1, -1);
        bus_cycle(26, 26, 16'hC0E0, 8'h22, 1'b0, 0, -1, -1);
        check("filt_level", 32'(level),  32'd1);
        check("filt_head",  32'(raddr),  32'hC081);
        check("filt_addr_o", 32'(addr_o), 32'hC0E0);
        lo = 16'hC090; hi = 16'hC080;
        bus_cycle(26, 26, 16'hC085, 8'h33, 1'b0, 0, -1, -1);
        check("filt_empty_window", 32'(level), 32'd1);
        check("filt_ovf",          32'(ovf),   32'd0);
        idle(4, 1'b1);
        lo = '0; hi = 16'hFFFF;
`endif

        // Random bus cycles, varied phase lengths, random consumer and clears
        for (int k = 0; k < 40; k++) begin
`ifndef A2BUS_CAPTURE_FILTER_EN
            lo = 16'($urandom); hi = 16'($urandom);
`endif
            bus_cycle($urandom_range(14, 34), $urandom_range(12, 34), 16'($urandom), 8'($urandom),
                      1'($urandom), 2, -1, (k == 20) ? $urandom_range(0, 30) : -1);
        end
        idle(10, 1'b1);
        check("final_level", 32'(level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
